// File: rtl/digit_vec_buffer_ctrl_pkg.sv
// rtl/digit_vec_buffer_ctrl_pkg.sv - shared state encodings and default sizes for the digit vector buffer
package digit_vec_buffer_ctrl_pkg;

  localparam int DEF_UNROLLING      = 4;
  localparam int DEF_RAM_ADDR_WIDTH = 7;

  typedef enum logic [2:0] {
    ST_START              = 3'd0,
    ST_WRITE_IN           = 3'd1,
    ST_READ_OUT           = 3'd2,
    ST_READ_OUT_LAST_LINE = 3'd3,
    ST_END                = 3'd4
  } state_t;

endpackage

// File: rtl/digit_vec_ram.sv
// rtl/digit_vec_ram.sv - simple dual-port buffer, synchronous write and synchronous registered read
module digit_vec_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset; array contents survive a reset.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset)  rd_data <= '0;
    else if (rd_en)  rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/digit_vec_buffer_ctrl.sv
// rtl/digit_vec_buffer_ctrl.sv - buffers a job of signed-digit words, then streams them back out
// Optional DIGIT_VEC_NORM_EN: clears digit positions where plus and minus are both set before storing.
module digit_vec_buffer_ctrl
  import digit_vec_buffer_ctrl_pkg::*;
#(
  parameter int UNROLLING      = DEF_UNROLLING,
  parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      asyn_reset,
  input  logic                      enable,
  input  logic                      start,
  input  logic [RAM_ADDR_WIDTH-1:0] comp_cycle,
  input  logic                      in_valid,
  input  logic [UNROLLING-1:0]      in_plus,
  input  logic [UNROLLING-1:0]      in_minus,
  output logic [2:0]                STATE,
  output logic [RAM_ADDR_WIDTH+1:0] master_cnt,
  output logic [UNROLLING-1:0]      x_vec_plus,
  output logic [UNROLLING-1:0]      x_vec_minus,
  output logic                      out_valid,
  output logic                      fix_next_state,
  output logic                      done
);

  localparam int AW = RAM_ADDR_WIDTH;

  state_t                 state, state_nxt;
  logic [AW-1:0]          cc, wr_addr, rd_addr, cc_m1, cc_m2;
  logic                   wr_req, rd_req, job_start, wr_en, rd_en, counting;
  logic [UNROLLING-1:0]   st_plus, st_minus;
  logic [2*UNROLLING-1:0] rd_data;

  assign cc_m1 = cc - AW'(1);
  assign cc_m2 = cc - AW'(2);

`ifdef DIGIT_VEC_NORM_EN
  assign st_plus  = in_plus  & ~(in_plus & in_minus);
  assign st_minus = in_minus & ~(in_plus & in_minus);
`else
  assign st_plus  = in_plus;
  assign st_minus = in_minus;
`endif

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset)  state <= ST_START;
    else if (enable) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    job_start = 1'b0;
    case (state)
      ST_START: begin
        if (start && comp_cycle != '0) begin
          job_start = 1'b1;
          state_nxt = ST_WRITE_IN;
        end
      end
      ST_WRITE_IN: begin
        if (in_valid) begin
          wr_req = 1'b1;
          if (wr_addr == cc_m1)
            state_nxt = (cc == AW'(1)) ? ST_READ_OUT_LAST_LINE : ST_READ_OUT;
        end
      end
      ST_READ_OUT: begin
        rd_req = 1'b1;
        if (rd_addr == cc_m2) state_nxt = ST_READ_OUT_LAST_LINE;
      end
      ST_READ_OUT_LAST_LINE: begin
        rd_req    = 1'b1;
        state_nxt = ST_END;
      end
      ST_END:  state_nxt = ST_START;
      default: state_nxt = ST_START;
    endcase
  end

  assign wr_en    = wr_req & enable;
  assign rd_en    = rd_req & enable;
  assign counting = (state == ST_WRITE_IN) || (state == ST_READ_OUT) ||
                    (state == ST_READ_OUT_LAST_LINE);

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      cc         <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      master_cnt <= '0;
      out_valid  <= 1'b0;
    end else if (enable) begin
      if (job_start) begin
        cc         <= comp_cycle;
        wr_addr    <= '0;
        rd_addr    <= '0;
        master_cnt <= '0;
      end else if (counting && master_cnt != '1) begin
        master_cnt <= master_cnt + 1'b1;
      end
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      if (rd_en) rd_addr <= rd_addr + 1'b1;
      out_valid <= rd_en;
    end
  end

  digit_vec_ram #(
    .WIDTH      (2*UNROLLING),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    ({st_plus, st_minus}),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  assign x_vec_plus     = rd_data[2*UNROLLING-1:UNROLLING];
  assign x_vec_minus    = rd_data[UNROLLING-1:0];
  assign STATE          = state;
  assign fix_next_state = (state == ST_READ_OUT_LAST_LINE);
  assign done           = (state == ST_END);

endmodule

// File: tb/tb_digit_vec_buffer_ctrl.sv
// tb/tb_digit_vec_buffer_ctrl.sv - scoreboard bench for digit_vec_buffer_ctrl
module tb_digit_vec_buffer_ctrl;

  localparam int U  = 4;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          asyn_reset = 1'b1;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] comp_cycle = '0;
  logic          in_valid = 1'b0;
  logic [U-1:0]  in_plus = '0, in_minus = '0;
  logic [2:0]    STATE;
  logic [AW+1:0] master_cnt;
  logic [U-1:0]  x_vec_plus, x_vec_minus;
  logic          out_valid, fix_next_state, done;

  typedef struct packed {
    logic [2*U-1:0] word;
    logic           last;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        pass_cnt = 0;
  int        chk_cnt  = 0;
  logic      last_en  = 1'b0;

  digit_vec_buffer_ctrl #(.UNROLLING(U), .RAM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .enable(enable), .start(start),
    .comp_cycle(comp_cycle), .in_valid(in_valid), .in_plus(in_plus),
    .in_minus(in_minus), .STATE(STATE), .master_cnt(master_cnt),
    .x_vec_plus(x_vec_plus), .x_vec_minus(x_vec_minus), .out_valid(out_valid),
    .fix_next_state(fix_next_state), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) last_en <= enable & ~asyn_reset;

  // A fresh output word exists only after an enabled edge with out_valid set.
  always @(negedge clk) begin
    if (last_en && out_valid && !asyn_reset) begin
      sb_entry_t e;
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow: got word %h with no expected entry", {x_vec_plus, x_vec_minus});
      end else begin
        e = sb.pop_front();
        if ({x_vec_plus, x_vec_minus} !== e.word || done !== e.last)
          $display("FAIL sb_word: got %h done=%b, expected %h done=%b",
                   {x_vec_plus, x_vec_minus}, done, e.word, e.last);
        else pass_cnt++;
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] cc);
    start = 1'b1; comp_cycle = cc;
    @(posedge clk); #1;
    start = 1'b0; comp_cycle = 7'h55;
  endtask

  task automatic write_word(input logic [U-1:0] p, input logic [U-1:0] m, input logic last);
    sb_entry_t e;
    logic [U-1:0] both;
    both = '0;
`ifdef DIGIT_VEC_NORM_EN
    both = p & m;
`endif
    e.word = {p & ~both, m & ~both};
    e.last = last;
    sb.push_back(e);
    in_valid = 1'b1; in_plus = p; in_minus = m;
    @(posedge clk); #1;
    in_valid = 1'b0; in_plus = 4'hF; in_minus = 4'hF;
  endtask

  task automatic wait_done(output logic ok, output int fix_cnt, output logic [AW+1:0] cnt_at_done);
    ok = 1'b0; fix_cnt = 0; cnt_at_done = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fix_next_state) fix_cnt++;
      if (done) begin
        ok = 1'b1; cnt_at_done = master_cnt;
        break;
      end
    end
  endtask

  task automatic test_reset;
    chk_cnt++;
    if ({STATE, master_cnt, x_vec_plus, x_vec_minus, out_valid, fix_next_state, done} !== '0)
      $display("FAIL reset_outputs: got state=%0d cnt=%0d x=%h/%h ov=%b fix=%b done=%b, expected all 0",
               STATE, master_cnt, x_vec_plus, x_vec_minus, out_valid, fix_next_state, done);
    else pass_cnt++;
    @(posedge clk); #1;
    asyn_reset = 1'b0; enable = 1'b1;
  endtask

  task automatic test_basic;
    logic ok; int fc; logic [AW+1:0] cnt;
    start_job(7'd3);
    write_word(4'b0011, 4'b0100, 1'b0);
    write_word(4'b1000, 4'b0000, 1'b0);
    write_word(4'b0001, 4'b0010, 1'b1);
    wait_done(ok, fc, cnt);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL basic_done: done not seen, expected within budget"); else pass_cnt++;
    chk_cnt++; if (cnt !== 9'd6) $display("FAIL basic_cnt: got %0d expected 6", cnt); else pass_cnt++;
    chk_cnt++; if (fc !== 1) $display("FAIL basic_fix: got %0d cycles expected 1", fc); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (sb.size() !== 0) $display("FAIL basic_drain: %0d left expected 0", sb.size()); else pass_cnt++;
    chk_cnt++; if (STATE !== 3'd0 || done !== 1'b0) $display("FAIL basic_return: state=%0d done=%b expected 0/0", STATE, done); else pass_cnt++;
  endtask

  task automatic test_single;
    start_job(7'd1);
    write_word(4'b1010, 4'b0101, 1'b1);
    @(negedge clk);
    chk_cnt++; if (STATE !== 3'd3 || fix_next_state !== 1'b1) $display("FAIL single_last_line: state=%0d fix=%b expected 3/1", STATE, fix_next_state); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (STATE !== 3'd4 || done !== 1'b1 || x_vec_plus !== 4'b1010) $display("FAIL single_end: state=%0d done=%b plus=%b expected 4/1/1010", STATE, done, x_vec_plus); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_gaps_freeze;
    logic ok; int fc; logic [AW+1:0] cnt;
    logic [2+AW+2+2*U:0] snap;
    start_job(7'd4);
    write_word(4'b0001, 4'b1000, 1'b0);
    @(posedge clk); #1;
    write_word(4'b0010, 4'b0100, 1'b0);
    write_word(4'b0100, 4'b0010, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    write_word(4'b1000, 4'b0001, 1'b1);
    @(posedge clk); #1;
    enable = 1'b0;
    snap = {STATE, master_cnt, x_vec_plus, x_vec_minus, out_valid};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if ({STATE, master_cnt, x_vec_plus, x_vec_minus, out_valid} !== snap)
        $display("FAIL freeze_hold: got %h expected %h", {STATE, master_cnt, x_vec_plus, x_vec_minus, out_valid}, snap);
      else pass_cnt++;
    end
    enable = 1'b1;
    wait_done(ok, fc, cnt);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL gaps_done: done not seen, expected within budget"); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (sb.size() !== 0) $display("FAIL gaps_drain: %0d left expected 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_zero_cc;
    start = 1'b1; comp_cycle = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (STATE !== 3'd0 || done !== 1'b0) $display("FAIL zero_cc: state=%0d done=%b expected 0/0", STATE, done);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset_mid_job;
    logic ok; int fc; logic [AW+1:0] cnt;
    start_job(7'd5);
    for (int i = 0; i < 5; i++) write_word(4'(i + 1), 4'(8 - i), (i == 4));
    @(posedge clk); #1;
    @(posedge clk); #1;
    asyn_reset = 1'b1;
    #1;
    chk_cnt++;
    if (STATE !== 3'd0 || out_valid !== 1'b0 || master_cnt !== '0 || {x_vec_plus, x_vec_minus} !== '0)
      $display("FAIL reset_mid: state=%0d ov=%b cnt=%0d x=%h expected 0/0/0/0", STATE, out_valid, master_cnt, {x_vec_plus, x_vec_minus});
    else pass_cnt++;
    sb.delete();
    @(negedge clk);
    asyn_reset = 1'b0;
    @(posedge clk); #1;
    start_job(7'd2);
    write_word(4'b0110, 4'b0001, 1'b0);
    write_word(4'b0000, 4'b1001, 1'b1);
    wait_done(ok, fc, cnt);
    chk_cnt++; if (ok !== 1'b1 || cnt !== 9'd4) $display("FAIL after_reset_job: ok=%b cnt=%0d expected 1/4", ok, cnt); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (sb.size() !== 0) $display("FAIL after_reset_drain: %0d left expected 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_norm;
    logic ok; int fc; logic [AW+1:0] cnt;
    start_job(7'd1);
    write_word(4'b1111, 4'b0101, 1'b1);
    wait_done(ok, fc, cnt);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL norm_done: done not seen, expected within budget"); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    #2;
    test_reset;
    test_basic;
    test_single;
    test_gaps_freeze;
    test_zero_cc;
    test_reset_mid_job;
    test_norm;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
